// File: rtl/sram_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes
// them to consecutive SRAM word addresses, holding the CPU in reset until done.
module sram_boot_loader #(
    parameter int SRAM_ADDR_W = 15,
    parameter int DATA_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SRAM_ADDR_W-2:0]   len,
    input  logic                     s_valid,
    input  logic [7:0]               s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [SRAM_ADDR_W-3:0]   m_addr,
    output logic [DATA_W-1:0]        m_wdata,
    output logic [DATA_W/8-1:0]      m_wstrb,
    input  logic                     m_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     cpu_rst
);
    localparam int AW = SRAM_ADDR_W - 2;
    localparam int LW = SRAM_ADDR_W - 1;
    localparam int SW = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, TURN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [LW-1:0]   len_reg, len_next;
    logic [LW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      idx_reg, idx_next;
    logic            stale_reg, stale_next;
    logic            s_ready_reg, s_ready_next;
    logic            m_valid_reg, m_valid_next;
    logic [AW-1:0]   m_addr_reg, m_addr_next;
    logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
    logic [SW-1:0]   m_wstrb_reg, m_wstrb_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            cpu_rst_reg, cpu_rst_next;

    logic            byte_acc;
    logic [SW-1:0]   lane_we;

    assign byte_acc = (state_reg == COLLECT) && s_valid && s_ready_reg;

    // Each accepted byte lands in the lane selected by the byte index.
    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_lane
            assign lane_we[gi] = byte_acc && (idx_reg == 2'(gi));
            assign m_wdata_next[8*gi +: 8] = lane_we[gi] ? s_data : m_wdata_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        stale_next   = stale_reg;
        s_ready_next = s_ready_reg;
        m_valid_next = m_valid_reg;
        m_addr_next  = m_addr_reg;
        m_wstrb_next = m_wstrb_reg;
        busy_next    = busy_reg;
        done_next    = done_reg;
        cpu_rst_next = cpu_rst_reg;

        // A ready that is still high from TURN must drop once before it counts.
        if (!m_ready) begin
            stale_next = 1'b0;
        end

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    len_next    = len;
                    cnt_next    = '0;
                    idx_next    = '0;
                    m_addr_next = '0;
                    if (len == '0) begin
                        state_next   = DONE;
                        busy_next    = 1'b0;
                        done_next    = 1'b1;
                        cpu_rst_next = 1'b0;
                    end else begin
                        state_next   = COLLECT;
                        s_ready_next = 1'b1;
                        busy_next    = 1'b1;
                        done_next    = 1'b0;
                        cpu_rst_next = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (byte_acc) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_next   = WRITE;
                        s_ready_next = 1'b0;
                        m_valid_next = 1'b1;
                        m_wstrb_next = '1;
                    end
                end
            end
            WRITE: begin
                if (m_ready && !stale_reg) begin
                    state_next   = TURN;
                    m_valid_next = 1'b0;
                    m_wstrb_next = '0;
                    cnt_next     = cnt_reg + 1'b1;
                end
            end
            TURN: begin
                if (m_ready) begin
                    stale_next = 1'b1;
                end
                if (cnt_reg == len_reg) begin
                    state_next   = DONE;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    cpu_rst_next = 1'b0;
                end else begin
                    state_next   = COLLECT;
                    m_addr_next  = m_addr_reg + 1'b1;
                    idx_next     = '0;
                    s_ready_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            stale_reg   <= 1'b0;
            s_ready_reg <= 1'b0;
            m_valid_reg <= 1'b0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
            m_wstrb_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            cpu_rst_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            stale_reg   <= stale_next;
            s_ready_reg <= s_ready_next;
            m_valid_reg <= m_valid_next;
            m_addr_reg  <= m_addr_next;
            m_wdata_reg <= m_wdata_next;
            m_wstrb_reg <= m_wstrb_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            cpu_rst_reg <= cpu_rst_next;
        end
    end

    assign s_ready = s_ready_reg;
    assign m_valid = m_valid_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;
    assign m_wstrb = m_wstrb_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign cpu_rst = cpu_rst_reg;

endmodule

// File: doc/sram_boot_loader.md
Name: sram_boot_loader

Overview:
- Initiator on the native valid/ready memory bus: the master side of the SRAM instruction port used for booting.
- Receives a little-endian byte stream (for example from the UART host link) and packs it into 32-bit words.
- Writes those words to consecutive SRAM word addresses starting at 0.
- Holds the CPU in reset until the programmed word count has been written, then releases it.

Parameters:
SRAM_ADDR_W, 15, SRAM byte-address width; the word address is SRAM_ADDR_W-2 bits.
DATA_W, 32, memory data width; only 32 is supported.

Ports:
clk  in  1  system clock.
rst  in  1  reset: synchronous, active-high.
start  in  1  one-cycle pulse; begins a load. Sampled only in IDLE or DONE.
len  in  SRAM_ADDR_W-1  number of words to load. Sampled when start is accepted.
s_valid  in  1  byte-stream valid.
s_data  in  8  byte-stream data.
s_ready  out  1  byte accepted when s_valid&&s_ready.
m_valid  out  1  memory request valid (connects to the SRAM i_valid).
m_addr  out  SRAM_ADDR_W-2  word address.
m_wdata  out  DATA_W  write data.
m_wstrb  out  DATA_W/8  byte strobes.
m_ready  in  1  memory ready (the SRAM returns ready one cycle after valid).
busy  out  1  high from start acceptance until DONE is entered.
done  out  1  level; high in DONE.
cpu_rst  out  1  CPU reset request; high everywhere except DONE.

Behaviour:
- Reset: next state is IDLE.
  - Output values in reset/IDLE: s_ready=0, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, busy=0, done=0, cpu_rst=1.
  - Internal counters are cleared.
  - rst asserted mid-load abandons the transfer; no further m_valid is issued.
- All outputs are registered.
- States: IDLE, COLLECT, WRITE, TURN, DONE.
- IDLE/DONE + start:
  - Latch len, clear byte index and word count, set m_addr=0.
  - If len==0, go to DONE directly (done the following cycle, no memory access).
  - Otherwise go to COLLECT, with busy=1, done=0 and cpu_rst=1.
- COLLECT:
  - s_ready=1.
  - Each accepted byte k (k=0..3) is written into m_wdata[8k+7:8k].
  - Acceptance of byte 3 moves to WRITE. m_valid=1 and m_wstrb=4'hF on the next cycle.
- WRITE:
  - s_ready=0.
  - m_valid, m_addr and m_wdata are held stable until m_ready is sampled high.
  - In that cycle the FSM moves to TURN: m_valid=0, m_wstrb=0, word count+1.
  - m_ready in the first WRITE cycle is ignored only if it is left over from TURN; see the turnaround rule below.
- TURN: one mandatory idle cycle.
  - m_ready is ignored here, because the SRAM's registered ready stays high one extra cycle after valid drops.
  - If word count==len, go to DONE.
  - Else increment m_addr, clear the byte index and go to COLLECT.
- DONE: busy=0, done=1, cpu_rst=0. Holds until rst or a new start.
- Because valid is held for two cycles against the SRAM, the same address is written twice with identical data. This is harmless and permitted.
- The address wraps modulo 2^(SRAM_ADDR_W-2).
  - len exceeding the memory depth is not checked; extra words wrap and overwrite from address 0.
- start while busy is ignored.
- s_valid while s_ready=0 is not consumed; the source must hold the byte.
- The byte stream may stall arbitrarily in COLLECT. There is no timeout.

Test Plan:
1. Reset and idle: assert rst 2 cycles, then release -> m_valid=0, s_ready=0, cpu_rst=1, busy=0, done=0. Then start with len=0 -> done=1 and cpu_rst=0 one cycle later, with no m_valid pulse.
2. Single word: start with len=1, then bytes 0x78,0x56,0x34,0x12 back-to-back, using an SRAM model (ready = valid delayed by 1) -> m_addr=0, m_wdata=0x12345678, m_wstrb=0xF. The memory reads 0x12345678 at word 0, and done=1 after TURN.
3. Multi-word with stalls: start with len=3, 12 bytes with random s_valid gaps -> writes at addresses 0,1,2 with the correct packed words. There is exactly one TURN cycle between writes, and s_ready=0 during WRITE and TURN.
4. Slow responder: m_ready delayed 5 cycles -> m_valid, m_addr and m_wdata stay stable for all 5 cycles, and the FSM advances only on m_ready.
5. Start while busy: len=2, pulse start again mid-load with len=7 -> the second start is ignored and exactly 2 words are written.
6. Reset mid-operation: assert rst during WRITE of word 1 of len=4 -> m_valid=0 next cycle and cpu_rst=1. A subsequent start with len=1 writes address 0 correctly.
